// File: rtl/vram_pkg.sv
// Shared types and constants for the dual-plane video RAM controller.
package vram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CPU_RD,
    ST_CPU_ACK,
    ST_FILL
  } state_t;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned PLANE_BIT = 10;
  localparam int unsigned RAM_DEPTH = 1024;

  localparam logic [7:0] DEF_FILL_CHAR  = 8'h20;
  localparam logic [7:0] DEF_FILL_COLOR = 8'h70;

endpackage

// File: rtl/vram_ctrl_if.sv
// CPU, video and fill signals of the video RAM controller.
interface vram_ctrl_if;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_we;
  logic        cpu_req;
  logic        cpu_ack;
  logic [7:0]  cpu_dout;
  logic        vid_slot;
  logic [9:0]  video_addr;
  logic [7:0]  video_data;
  logic [7:0]  video_color;
  logic        fill_start;
  logic        fill_busy;

  modport master (
    output cpu_addr, cpu_din, cpu_we, cpu_req, vid_slot, video_addr, fill_start,
    input  cpu_ack, cpu_dout, video_data, video_color, fill_busy
  );

  modport slave (
    input  cpu_addr, cpu_din, cpu_we, cpu_req, vid_slot, video_addr, fill_start,
    output cpu_ack, cpu_dout, video_data, video_color, fill_busy
  );
endinterface

// File: rtl/vram_spram.sv
// 1024x8 single-port synchronous RAM, one-cycle read latency, no reset.
module vram_spram
  import vram_pkg::*;
(
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        din_i,
  output logic [7:0]        dout_o
);

  logic [7:0] mem_q [RAM_DEPTH];
  logic [7:0] dout_q;

  // Write on enabled write cycles; read data registered on enabled read cycles.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= din_i;
      else      dout_q        <= mem_q[addr_i];
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/vram_ctrl.sv
// Video RAM controller: screen and color planes shared by video slots,
// a CPU port and a clear-screen fill engine. Video slots always win.
module vram_ctrl
  import vram_pkg::*;
#(
  parameter logic [7:0] FILL_CHAR     = DEF_FILL_CHAR,
  parameter logic [7:0] FILL_COLOR    = DEF_FILL_COLOR,
  parameter bit         FILL_ON_RESET = 1'b1
) (
  input  logic       clk_sys,
  input  logic       reset,
  vram_ctrl_if.slave bus
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              fill_pend_q, fill_pend_d;
  logic              slot_q;
  logic [7:0]        cpu_dout_q, video_data_q, video_color_q;

  logic              grant;
  logic              plane_sel;
  logic [ADDR_W-1:0] ram_addr;
  logic              scr_en, col_en, ram_we;
  logic [7:0]        scr_din, col_din, scr_dout, col_dout;

  assign plane_sel = bus.cpu_addr[PLANE_BIT];
  // A pending fill outranks a new CPU request once the controller is idle.
  assign grant = (state_q == ST_IDLE) && !fill_pend_q && bus.cpu_req && !bus.vid_slot;

  // State, fill counter and deferred-fill flag; reset re-arms the power-up fill.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      fill_pend_q <= FILL_ON_RESET;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_pend_q <= fill_pend_d;
    end
  end

  // Next-state: CPU grant, fill entry/deferral, fill progress.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_pend_d = fill_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d     = bus.cpu_we ? ST_CPU_ACK : ST_CPU_RD;
          fill_pend_d = bus.fill_start;
        end else if (fill_pend_q || bus.fill_start) begin
          state_d     = ST_FILL;
          cnt_d       = '0;
          fill_pend_d = 1'b0;
        end
      end
      ST_CPU_RD: begin
        state_d = ST_CPU_ACK;
        if (bus.fill_start) fill_pend_d = 1'b1;
      end
      ST_CPU_ACK: begin
        state_d = ST_IDLE;
        if (bus.fill_start) fill_pend_d = 1'b1;
      end
      ST_FILL: begin
        if (!bus.vid_slot) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // RAM port arbitration: video slot, then CPU grant, then fill write.
  always_comb begin
    ram_addr = cnt_q;
    scr_en   = 1'b0;
    col_en   = 1'b0;
    ram_we   = 1'b0;
    scr_din  = FILL_CHAR;
    col_din  = FILL_COLOR;
    if (bus.vid_slot) begin
      ram_addr = bus.video_addr;
      scr_en   = 1'b1;
      col_en   = 1'b1;
    end else if (grant) begin
      ram_addr = bus.cpu_addr[ADDR_W-1:0];
      scr_en   = !plane_sel;
      col_en   = plane_sel;
      ram_we   = bus.cpu_we;
      scr_din  = bus.cpu_din;
      col_din  = bus.cpu_din;
    end else if (state_q == ST_FILL) begin
      scr_en = 1'b1;
      col_en = 1'b1;
      ram_we = 1'b1;
    end
  end

  // Read-data capture: video bytes one cycle after the slot, CPU byte in CPU_RD.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      slot_q        <= 1'b0;
      cpu_dout_q    <= '0;
      video_data_q  <= '0;
      video_color_q <= '0;
    end else begin
      slot_q <= bus.vid_slot;
      if (slot_q) begin
        video_data_q  <= scr_dout;
        video_color_q <= col_dout;
      end
      if (state_q == ST_CPU_RD) cpu_dout_q <= plane_sel ? col_dout : scr_dout;
    end
  end

  vram_spram u_screen (
    .clk_i  (clk_sys),
    .en_i   (scr_en),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .din_i  (scr_din),
    .dout_o (scr_dout)
  );

  vram_spram u_color (
    .clk_i  (clk_sys),
    .en_i   (col_en),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .din_i  (col_din),
    .dout_o (col_dout)
  );

  assign bus.cpu_ack     = (state_q == ST_CPU_ACK);
  assign bus.cpu_dout    = cpu_dout_q;
  assign bus.video_data  = video_data_q;
  assign bus.video_color = video_color_q;
  assign bus.fill_busy   = (state_q == ST_FILL);

endmodule

// File: doc/vram_ctrl.md
VRAM_CTRL -- requirements
Module: vram_ctrl

Interface
REQ-001 Parameter FILL_CHAR, default 8'h20, character code written to every screen cell by the fill engine.
REQ-002 Parameter FILL_COLOR, default 8'h70, attribute written to every color cell by the fill engine.
REQ-003 Parameter FILL_ON_RESET, default 1, starts a fill automatically on the first cycle after reset deasserts.
REQ-004 clk_sys  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cpu_addr  in  11  bit 10: 0 = screen plane, 1 = color plane; bits 9:0 = cell index.
REQ-007 cpu_din  in  8  CPU write data.
REQ-008 cpu_we  in  1  1 = write, 0 = read; qualified by cpu_req.
REQ-009 cpu_req  in  1  level request, held stable with addr/din/we until cpu_ack.
REQ-010 cpu_ack  out  1  one-cycle completion pulse.
REQ-011 cpu_dout  out  8  read data, valid in the cpu_ack cycle of a read and held until the next read completes.
REQ-012 vid_slot  in  1  one-cycle video read strobe.
REQ-013 video_addr  in  10  cell index sampled when vid_slot = 1.
REQ-014 video_data  out  8  screen-plane byte for the last slot.
REQ-015 video_color  out  8  color-plane byte for the last slot.
REQ-016 fill_start  in  1  pulse requesting a fill.
REQ-017 fill_busy  out  1  high while the fill engine owns the RAMs.

Function
REQ-018 Storage SHALL be two single-port 1024x8 synchronous RAMs (screen, color) with 1-cycle read latency and one shared address/enable per cycle.
REQ-019 vid_slot SHALL have absolute priority: in a slot cycle N both RAMs are addressed with video_addr, and no CPU or fill access occurs in N.
REQ-020 video_data/video_color SHALL load the RAM outputs at the end of cycle N+1, be visible from cycle N+2, and hold until the next slot.
REQ-021 State machine states: IDLE, CPU_RD, CPU_ACK, FILL.
REQ-022 IDLE + cpu_req + !vid_slot SHALL grant in that cycle G: a write writes the selected plane in G, pulses cpu_ack in G+1 and enters CPU_ACK; a read addresses the selected plane in G and enters CPU_RD.
REQ-023 CPU_RD SHALL capture the selected plane's RAM output into cpu_dout at the end of G+1, pulse cpu_ack in G+2, and enter CPU_ACK.
REQ-024 A vid_slot in G+1 SHALL be serviced normally without corrupting the CPU read data.
REQ-025 CPU_ACK SHALL return to IDLE after one cycle and SHALL NOT grant in that cycle, so a request still high in the ack cycle is not double-serviced.
REQ-026 A grant blocked by vid_slot SHALL be retried on the next non-slot cycle with no lost or duplicated access.
REQ-027 fill_start in IDLE SHALL enter FILL, clear a 10-bit counter, and raise fill_busy the next cycle.
REQ-028 fill_start during FILL SHALL be ignored; fill_start coincident with a CPU grant SHALL be deferred until IDLE.
REQ-029 FILL SHALL write FILL_CHAR and FILL_COLOR at the counter address in every non-slot cycle and then increment the counter.
REQ-030 FILL SHALL return to IDLE after the write at address 1023; fill_busy SHALL drop in that same transition, so exactly 1024 writes occur per plane.
REQ-031 While fill_busy = 1, cpu_req SHALL stall without cpu_ack; video slots during FILL SHALL still return current RAM contents.

Reset
REQ-032 Reset SHALL force state IDLE, cpu_ack = 0, cpu_dout = 8'h00, video_data = 8'h00, video_color = 8'h00, fill_busy = 0, and counter = 0.
REQ-033 RAM contents SHALL NOT be reset.
REQ-034 Reset mid-operation SHALL abort any CPU access or fill without an ack; with FILL_ON_RESET = 1, a complete fill SHALL restart from address 0.

Structure
REQ-035 Shared package vram_pkg SHALL hold the state enum, the plane-select bit index (10), the RAM depth (1024), and default fill constants.
REQ-036 A single sub-module vram_spram (1024x8 single-port synchronous RAM) SHALL be instantiated twice.

Verification
REQ-037 Reset with FILL_ON_RESET = 1 and no slots -> fill_busy high for 1024 cycles; then video reads of cells 0, 512 and 1023 return 8'h20 / 8'h70.
REQ-038 CPU write 8'hA5 to 11'h005, then read 11'h005 -> write ack in G+1, read ack in G+2 with cpu_dout = 8'hA5; color cell 5 unchanged.
REQ-039 vid_slot asserted in the same cycle a cpu_req arrives -> grant moves to the next cycle, and video_data is correct at N+2.
REQ-040 CPU read with vid_slot in G+1 -> both cpu_dout and video_data/video_color carry their respective correct cells.
REQ-041 Slots every 4th cycle during a fill -> fill completes in exactly 1024 non-slot cycles; a pending cpu_req is acked only after fill_busy falls.
REQ-042 Reset asserted at counter = 300 -> no ack, the fill restarts, and all 1024 cells end filled.
